// File: rtl/shift_chain_ctrl_pkg.sv
// Shared definitions for the shift-chain sequencer: FSM state encoding and default sizing.
package shift_chain_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 3;
  localparam logic        DEF_FILL  = 1'b0;

endpackage

// File: rtl/shift_bit_cnt.sv
// Bit counter for the serial phase: counts 0..WIDTH-1 while enabled, wrapping at terminal count.
module shift_bit_cnt #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_r;

  assign tc = (cnt_r == CNT_W'(WIDTH - 1));

  // Counter register: cleared outside the shift phase, wraps explicitly so WIDTH need not be a power of two.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= tc ? '0 : cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/shift_chain_ctrl.sv
// Sequencer that loads a parallel word into an external shift-cell chain and streams
// the chain tail out serially, MSB first, with valid/last flags and a done pulse.
module shift_chain_ctrl
  import shift_chain_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter logic        FILL  = DEF_FILL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic [WIDTH-1:0] chain_par,
  output logic             chain_shiftr,
  output logic             chain_sin,
  input  logic             chain_tail,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             done,
  output logic             busy
);

  state_e           state_r;
  logic [WIDTH-1:0] data_q_r;
  logic             ser_out_r;
  logic             ser_valid_r;
  logic             ser_last_r;
  logic             done_r;
  logic             busy_r;
  logic             shiftr_r;
  logic             ready_r;
  logic             cnt_en_s;
  logic             cnt_tc_s;

  assign cnt_en_s = (state_r == S_SHIFT);

  shift_bit_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (~cnt_en_s),
    .en  (cnt_en_s),
    .tc  (cnt_tc_s)
  );

  // Control FSM; status outputs are registered from the next state so they line up with state_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      data_q_r    <= '0;
      ser_out_r   <= 1'b0;
      ser_valid_r <= 1'b0;
      ser_last_r  <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      shiftr_r    <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      ser_valid_r <= 1'b0;
      ser_last_r  <= 1'b0;
      done_r      <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (load_valid && ready_r) begin
            data_q_r <= load_data;
            state_r  <= S_LOAD;
            busy_r   <= 1'b1;
            ready_r  <= 1'b0;
            shiftr_r <= 1'b0;
          end
        end
        S_LOAD: begin
          state_r  <= S_SHIFT;
          shiftr_r <= 1'b1;
        end
        S_SHIFT: begin
          ser_out_r   <= chain_tail;
          ser_valid_r <= 1'b1;
          ser_last_r  <= cnt_tc_s;
          if (cnt_tc_s) begin
            state_r  <= S_DONE;
            shiftr_r <= 1'b0;
            done_r   <= 1'b1;
          end
        end
        S_DONE: begin
          state_r  <= S_IDLE;
          busy_r   <= 1'b0;
          ready_r  <= 1'b1;
          shiftr_r <= 1'b0;
        end
        default: begin
          state_r  <= S_IDLE;
          busy_r   <= 1'b0;
          ready_r  <= 1'b1;
          shiftr_r <= 1'b0;
        end
      endcase
    end
  end

  // Outside LOAD/SHIFT the cells simply reload the held word, which is harmless.
  assign chain_par    = data_q_r;
  assign chain_shiftr = shiftr_r;
  assign chain_sin    = FILL;
  assign load_ready   = ready_r & ~rst;
  assign ser_out      = ser_out_r;
  assign ser_valid    = ser_valid_r;
  assign ser_last     = ser_last_r;
  assign done         = done_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// Scoreboard bench: stimulus queues expected serial bits, a monitor pops them on ser_valid.
module tb_shift_chain_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] load_data = '0;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [W-1:0] chain_par;
  logic         chain_shiftr;
  logic         chain_sin;
  logic         chain_tail;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_last;
  logic         done;
  logic         busy;
  logic [W-1:0] cells;

  int checks = 0;
  int failures = 0;

  typedef struct packed { logic b; logic last; } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  shift_chain_ctrl #(.WIDTH(W), .CNT_W(3), .FILL(1'b0)) dut (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .chain_par(chain_par), .chain_shiftr(chain_shiftr),
    .chain_sin(chain_sin), .chain_tail(chain_tail), .ser_out(ser_out),
    .ser_valid(ser_valid), .ser_last(ser_last), .done(done), .busy(busy)
  );

  // Chain of W shift cells, cell i feeds cell i+1.
  always @(posedge clk) begin
    if (chain_shiftr) cells <= {cells[W-2:0], chain_sin};
    else              cells <= chain_par;
  end
  assign chain_tail = cells[W-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) exp_q.push_back('{b: w[i], last: (i == 0)});
  endtask

  // Monitor: every valid serial bit must match the head of the scoreboard.
  always @(negedge clk) begin
    if (ser_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_bit: got ser_out=%0b with empty scoreboard at %0t", ser_out, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ser_out", {31'd0, ser_out}, {31'd0, e.b});
        chk("ser_last", {31'd0, ser_last}, {31'd0, e.last});
        chk("done_with_last", {31'd0, done}, {31'd0, e.last});
      end
    end else if (done === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL done_without_valid: got done=1 expected 0 at %0t", $time);
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (load_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", {31'd0, load_ready}, 32'd1);
  endtask

  // One transaction with cycle-exact control checks; optionally offers a word mid-shift.
  task automatic run_timed(input logic [W-1:0] w, input bit inject);
    wait_ready();
    load_data  = w;
    load_valid = 1'b1;
    push_word(w);
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (j == 1) load_valid = 1'b0;
      chk("busy", {31'd0, busy}, {31'd0, (j >= 1 && j <= 10)});
      chk("load_ready", {31'd0, load_ready}, {31'd0, (j >= 11)});
      chk("chain_shiftr", {31'd0, chain_shiftr}, {31'd0, (j >= 2 && j <= 9)});
      chk("ser_valid", {31'd0, ser_valid}, {31'd0, (j >= 3 && j <= 10)});
      chk("done", {31'd0, done}, {31'd0, (j == 10)});
      if (chain_shiftr === 1'b1) chk("chain_sin", {31'd0, chain_sin}, 32'd0);
      if (inject && j == 4) begin
        load_data  = 8'h3C;
        load_valid = 1'b1;
      end
      if (inject && j == 7) load_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    // Reset held three cycles.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_ser_valid", {31'd0, ser_valid}, 32'd0);
      chk("rst_ser_last", {31'd0, ser_last}, 32'd0);
      chk("rst_ser_out", {31'd0, ser_out}, 32'd0);
      chk("rst_shiftr", {31'd0, chain_shiftr}, 32'd0);
      chk("rst_par", {24'd0, chain_par}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, load_ready}, 32'd1);
    chk("post_rst_valid", {31'd0, ser_valid}, 32'd0);

    run_timed(8'hA5, 1'b0);

    // Back-to-back FF then 00 with load_valid held high.
    load_data  = 8'hFF;
    load_valid = 1'b1;
    push_word(8'hFF);
    push_word(8'h00);
    for (int j = 1; j <= 22; j++) begin
      @(negedge clk);
      if (j == 1) load_data = 8'h00;
      chk("b2b_busy", {31'd0, busy}, {31'd0, ((j >= 1 && j <= 10) || (j >= 12 && j <= 21))});
      chk("b2b_ready", {31'd0, load_ready}, {31'd0, (j == 11 || j >= 22)});
      chk("b2b_valid", {31'd0, ser_valid}, {31'd0, ((j >= 3 && j <= 10) || (j >= 14 && j <= 21))});
      chk("b2b_done", {31'd0, done}, {31'd0, (j == 10 || j == 21)});
      if (j == 12) load_valid = 1'b0;
    end

    run_timed(8'hC3, 1'b1);
    repeat (3) @(negedge clk);
    chk("no_extra_txn_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of serializing 8'h81.
    wait_ready();
    load_data  = 8'h81;
    load_valid = 1'b1;
    push_word(8'h81);
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      if (j == 1) load_valid = 1'b0;
      if (j == 5) begin
        chk("mid_valid_before_rst", {31'd0, ser_valid}, 32'd1);
        rst = 1'b1;
      end
      if (j == 6) begin
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, ser_valid}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_ready", {31'd0, load_ready}, 32'd0);
        exp_q.delete();
        rst = 1'b0;
      end
      if (j == 7) begin
        chk("mid_after_ready", {31'd0, load_ready}, 32'd1);
        chk("mid_after_valid", {31'd0, ser_valid}, 32'd0);
      end
    end
    run_timed(8'h01, 1'b0);
    run_timed(8'h80, 1'b0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
